// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
//   Data memory stage of the single-cycle RV32I datapath. Byte-addressed,
//   little-endian, word-organised storage with RISC-V funct3 load/store
//   sizing, combinational read path and byte-lane write enables. Misaligned,
//   out-of-range and illegal accesses are flagged combinationally and
//   recorded in a sticky fault register (first faulting address wins).
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (clears memory and fault record)
//   Address      byte address (from ALU result)
//   DataWr       store data (from rs2)
//   DMWr         store enable
//   DMRd         load qualifier (only affects fault detection)
//   DMCtrl       funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   FaultClr     clears the sticky fault at the next edge
//   DataRd       load result, sign/zero extended per DMCtrl
//   Fault        combinational fault for the current access
//   FaultSticky  registered, set on any faulting cycle
//   FaultAddr    registered, address of first fault since last clear
// ---------------------------------------------------------------------------
module data_memory #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic        DMWr,
    input  logic        DMRd,
    input  logic [2:0]  DMCtrl,
    input  logic        FaultClr,
    output logic [31:0] DataRd,
    output logic        Fault,
    output logic        FaultSticky,
    output logic [31:0] FaultAddr
);

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          out_of_range;
    logic          illegal;
    logic          misaligned;
    logic          bad;
    logic [31:0]   rd_word;
    logic [31:0]   shifted;
    logic [3:0]    wmask;
    logic [31:0]   wdata;

    always_comb begin
        idx          = Address[AW+1:2];
        out_of_range = (Address >> (AW + 2)) != '0;

        illegal    = 1'b0;
        misaligned = 1'b0;
        case (DMCtrl)
            3'b000:  ;
            3'b001:  misaligned = Address[0];
            3'b010:  misaligned = Address[1:0] != 2'b00;
            // Unsigned variants exist only for loads.
            3'b100:  illegal = DMWr;
            3'b101:  begin
                         illegal    = DMWr;
                         misaligned = Address[0];
                     end
            default: illegal = 1'b1;
        endcase

        bad   = out_of_range | illegal | misaligned;
        Fault = (DMWr | DMRd) & bad;

        // Move the addressed byte/half down to bit 0; aligned halves only
        // ever shift by 0 or 16.
        rd_word = mem[idx];
        shifted = rd_word >> {Address[1:0], 3'b000};

        DataRd = '0;
        if (!bad) begin
            case (DMCtrl)
                3'b000:  DataRd = {{24{shifted[7]}}, shifted[7:0]};
                3'b100:  DataRd = {24'h0, shifted[7:0]};
                3'b001:  DataRd = {{16{shifted[15]}}, shifted[15:0]};
                3'b101:  DataRd = {16'h0, shifted[15:0]};
                3'b010:  DataRd = rd_word;
                default: DataRd = '0;
            endcase
        end

        // Replicate store data across lanes so the mask alone picks the lane.
        wmask = '0;
        wdata = DataWr;
        case (DMCtrl[1:0])
            2'b00: begin
                       wmask = 4'b0001 << Address[1:0];
                       wdata = {4{DataWr[7:0]}};
                   end
            2'b01: begin
                       wmask = Address[1] ? 4'b1100 : 4'b0011;
                       wdata = {2{DataWr[15:0]}};
                   end
            2'b10: wmask = 4'b1111;
            default: wmask = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (DMWr && !bad) begin
            if (wmask[0]) mem[idx][7:0]   <= wdata[7:0];
            if (wmask[1]) mem[idx][15:8]  <= wdata[15:8];
            if (wmask[2]) mem[idx][23:16] <= wdata[23:16];
            if (wmask[3]) mem[idx][31:24] <= wdata[31:24];
        end
    end

    // A new fault outranks FaultClr; only the first fault's address is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            FaultSticky <= 1'b0;
            FaultAddr   <= '0;
        end else if (Fault) begin
            FaultSticky <= 1'b1;
            if (!FaultSticky) FaultAddr <= Address;
        end else if (FaultClr) begin
            FaultSticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// ---------------------------------------------------------------------------
// tb_data_memory
//   Scoreboard bench for data_memory: a byte-addressed reference model
//   produces the expected response of every operation, which is queued and
//   compared by an independent monitor on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_data_memory;

    localparam int unsigned DEPTH = 1024;
    localparam logic [2:0] C_B  = 3'b000, C_H = 3'b001, C_W = 3'b010;
    localparam logic [2:0] C_BU = 3'b100, C_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        DMWr;
    logic        DMRd;
    logic [2:0]  DMCtrl;
    logic        FaultClr;
    logic [31:0] DataRd;
    logic        Fault;
    logic        FaultSticky;
    logic [31:0] FaultAddr;

    always #5 clk = ~clk;

    data_memory #(.DEPTH_WORDS(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .Address     (Address),
        .DataWr      (DataWr),
        .DMWr        (DMWr),
        .DMRd        (DMRd),
        .DMCtrl      (DMCtrl),
        .FaultClr    (FaultClr),
        .DataRd      (DataRd),
        .Fault       (Fault),
        .FaultSticky (FaultSticky),
        .FaultAddr   (FaultAddr)
    );

    // Reference model: sparse byte memory plus fault record.
    bit [7:0]    mbytes [int unsigned];
    bit          m_st = 1'b0;
    bit [31:0]   m_fa = '0;

    typedef struct {
        int unsigned id;
        logic [31:0] rd;
        logic        f;
        logic        st;
        logic [31:0] fa;
    } exp_t;

    exp_t        q[$];
    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned n_ops    = 0;

    function automatic int unsigned acc_size(input logic [2:0] c);
        return 1 << c[1:0];
    endfunction

    function automatic bit model_bad(input logic [31:0] a, input logic [2:0] c, input bit w);
        if (c == 3'b011 || c == 3'b110 || c == 3'b111) return 1'b1;
        if (w && c[2]) return 1'b1;
        if ((a % acc_size(c)) != 0) return 1'b1;
        if (a >= 4 * DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] c);
        int unsigned sz;
        logic [31:0] val;
        logic [7:0]  b;
        sz  = acc_size(c);
        val = '0;
        for (int unsigned i = 0; i < sz; i++) begin
            b   = mbytes.exists(a + i) ? mbytes[a + i] : 8'h00;
            val = val | (32'(b) << (8 * i));
        end
        if (!c[2] && sz < 4 && val[8 * sz - 1]) val = val | (32'hFFFF_FFFF << (8 * sz));
        return val;
    endfunction

    task automatic op(input bit r, input logic [31:0] a, input logic [31:0] wd,
                      input bit w, input bit rd, input logic [2:0] c, input bit clr);
        exp_t e;
        bit   bad;
        bit   f;
        logic [31:0] tmp;
        @(posedge clk);
        #1;
        rst = r; Address = a; DataWr = wd; DMWr = w; DMRd = rd; DMCtrl = c; FaultClr = clr;
        bad  = model_bad(a, c, w);
        f    = (w || rd) && bad;
        e.id = n_ops;
        e.rd = bad ? 32'h0 : model_read(a, c);
        e.f  = f;
        e.st = m_st;
        e.fa = m_fa;
        q.push_back(e);
        n_ops++;
        // Model state after the coming edge.
        if (r) begin
            mbytes.delete();
            m_st = 1'b0;
            m_fa = '0;
        end else begin
            if (w && !bad) begin
                tmp = wd;
                for (int unsigned i = 0; i < acc_size(c); i++) begin
                    mbytes[a + i] = tmp[7:0];
                    tmp = tmp >> 8;
                end
            end
            if (f) begin
                if (!m_st) m_fa = a;
                m_st = 1'b1;
            end else if (clr) begin
                m_st = 1'b0;
            end
        end
    endtask

    task automatic check(input string nm, input int unsigned id,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s op=%0d actual=%h required=%h", nm, id, act, exp);
        end
    endtask

    // Monitor: every queued expectation is compared in its own cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("DataRd",      e.id, DataRd,              e.rd);
            check("Fault",       e.id, {31'h0, Fault},       {31'h0, e.f});
            check("FaultSticky", e.id, {31'h0, FaultSticky}, {31'h0, e.st});
            check("FaultAddr",   e.id, FaultAddr,           e.fa);
        end
    end

    initial begin
        logic [31:0] ra;
        int unsigned sel;

        rst = 1'b1; Address = '0; DataWr = '0; DMWr = 1'b0; DMRd = 1'b0;
        DMCtrl = C_W; FaultClr = 1'b0;
        repeat (2) @(posedge clk);

        // Post-reset reads.
        op(0, 32'h000, 32'h0, 0, 1, C_W, 0);
        op(0, 32'h004, 32'h0, 0, 1, C_W, 0);
        op(0, 32'h3FC, 32'h0, 0, 1, C_W, 0);

        // Sign/zero extension.
        op(0, 32'h10, 32'h8000_80F0, 1, 0, C_W, 0);
        op(0, 32'h10, 32'h0, 0, 1, C_B,  0);
        op(0, 32'h10, 32'h0, 0, 1, C_BU, 0);
        op(0, 32'h12, 32'h0, 0, 1, C_H,  0);
        op(0, 32'h12, 32'h0, 0, 1, C_HU, 0);
        op(0, 32'h10, 32'h0, 0, 1, C_W,  0);

        // Byte lanes.
        op(0, 32'h20, 32'h1122_3344, 1, 0, C_W, 0);
        op(0, 32'h21, 32'h0000_00AA, 1, 0, C_B, 0);
        op(0, 32'h22, 32'h0000_BEEF, 1, 0, C_H, 0);
        op(0, 32'h20, 32'h0, 0, 1, C_W, 0);

        // Misaligned store, first-fault capture, clear.
        op(0, 32'h31, 32'hDEAD_BEEF, 1, 0, C_W, 0);
        op(0, 32'h30, 32'h0, 0, 1, C_W, 0);
        op(0, 32'h33, 32'h0, 0, 1, C_H, 0);
        op(0, 32'h00, 32'h0, 0, 0, C_W, 1);
        op(0, 32'h00, 32'h0, 0, 0, C_W, 0);

        // Clear collides with an out-of-range load; illegal funct3.
        op(0, 32'h1000, 32'h0, 0, 1, C_W, 1);
        op(0, 32'h00, 32'h0, 0, 0, C_W, 0);
        op(0, 32'h00, 32'h0, 0, 1, 3'b011, 0);

        // Read-during-write, then reset discarding a pending store.
        op(0, 32'h40, 32'h1234_5678, 1, 1, C_W, 0);
        op(0, 32'h40, 32'h0, 0, 1, C_W, 0);
        op(1, 32'h40, 32'h0000_0055, 1, 0, C_W, 0);
        op(0, 32'h40, 32'h0, 0, 1, C_W, 0);

        // Randomized traffic.
        for (int unsigned n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)       ra = 32'($urandom_range(0, 255));
            else if (sel == 8) ra = 32'($urandom_range(0, 4 * DEPTH + 7));
            else               ra = $urandom;
            op($urandom_range(0, 99) == 0, ra, $urandom,
               $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
        end
        op(0, 32'h0, 32'h0, 0, 0, C_W, 0);

        for (int unsigned i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data memory stage of the single-cycle RV32I datapath, directly downstream of the ALU.
- Uses the ALU result (ALURes) as the byte address and rs2 as store data.
- Implements LB/LH/LW/LBU/LHU and SB/SH/SW using RISC-V funct3 encoding, little-endian, with byte-lane write enables.
- Detects misaligned, out-of-range and illegal accesses and keeps a sticky fault record for debug and trap logic.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, minimum 4.
- AW, $clog2(DEPTH_WORDS), word-index width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- Address  in  32  byte address, driven from ALURes.
- DataWr  in  32  store data, driven from rs2.
- DMWr  in  1  store enable.
- DMRd  in  1  load qualifier; used only for fault detection.
- DMCtrl  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 illegal.
- FaultClr  in  1  clears the sticky fault at the next edge.
- DataRd  out  32  load result, extended per DMCtrl.
- Fault  out  1  combinational fault for the current access.
- FaultSticky  out  1  registered; set on any faulting cycle.
- FaultAddr  out  32  registered; Address of the first fault since the last clear.

Behaviour:
- Storage: mem[0..DEPTH_WORDS-1], 32 bits each. Word index = Address[AW+1:2].
- OutOfRange: Address[31:AW+2] != 0.
- Illegal: DMCtrl in {011,110,111}. Stores also treat 100/101 as illegal.
- Misaligned: halfword access with Address[0]=1, or word access with Address[1:0]!=0.
- Bad = OutOfRange | Illegal | Misaligned.
- Fault = (DMWr | DMRd) & Bad. Purely combinational, no latency.
- Read path is combinational (zero-latency), required by the single-cycle datapath:
  - Bad access → DataRd = 0.
  - Byte lane = Address[1:0]; half lane = Address[1].
  - 000: sign-extend the byte. 100: zero-extend the byte.
  - 001: sign-extend the half. 101: zero-extend the half.
  - 010: full word.
  - DataRd is valid whether or not DMRd is asserted.
- Write path: at the rising edge, when DMWr=1, rst=0 and Bad=0:
  - SB writes DataWr[7:0] into the addressed lane.
  - SH writes DataWr[15:0] into lanes {1:0} or {3:2}.
  - SW writes the full word.
  - Unaddressed lanes are preserved.
  - A faulting store writes nothing.
- DMWr and DMRd high in the same cycle: DataRd shows pre-write contents that cycle; new data is visible after the edge.
- Sticky fault register, evaluated at each edge, in priority order:
  1. rst → FaultSticky=0, FaultAddr=0.
  2. Fault=1 and FaultSticky=0 → FaultSticky=1, FaultAddr=Address.
  3. Fault=1 and FaultSticky=1 → FaultSticky stays 1, FaultAddr held (first fault wins).
  4. FaultClr=1 and Fault=0 → FaultSticky=0, FaultAddr held.
  5. Otherwise hold.
  - FaultClr together with Fault: set wins; FaultAddr captures the current Address only if FaultSticky was 0.
- Reset (synchronous):
  - At the edge with rst=1, every memory word is cleared to 0, FaultSticky=0 and FaultAddr=0.
  - Any store in that cycle is suppressed.
  - During the rst cycle DataRd still reflects pre-reset contents (combinational).
  - Reset asserted mid-sequence discards all prior stores.
- Reset values: FaultSticky=0, FaultAddr=0. DataRd=0 after reset for any legal read, since memory is zero. Fault is combinational and has no reset value.
- Address wrap: none. Any address ≥ 4*DEPTH_WORDS faults.

Test Plan:
- Reset, then LW at 0x00, 0x04 and 0x3FC → DataRd=0x00000000. FaultSticky=0, FaultAddr=0.
- SW 0x8000_80F0 @0x10, then:
  - LB @0x10 → 0xFFFFFFF0; LBU @0x10 → 0x000000F0.
  - LH @0x12 → 0xFFFF8000; LHU @0x12 → 0x00008000.
  - LW @0x10 → 0x800080F0.
- Byte lanes: SW 0x11223344 @0x20, SB 0xAA @0x21, SH 0xBEEF @0x22, then LW @0x20 → 0xBEEFAA44.
- Misaligned SW 0xDEADBEEF @0x31:
  - Fault=1 that cycle; LW @0x30 afterwards → 0 (no write).
  - FaultSticky=1, FaultAddr=0x31.
  - Then LH @0x33 → FaultAddr stays 0x31.
  - FaultClr with no access → FaultSticky=0.
- FaultClr together with an out-of-range LW @0x0000_1000 (DEPTH_WORDS=1024) → DataRd=0, FaultSticky=1, FaultAddr=0x1000. Illegal DMCtrl=011 with DMRd → Fault=1, DataRd=0.
- SW 0x12345678 @0x40 with DMRd in the same cycle: DataRd shows the old 0 that cycle and 0x12345678 next cycle. Then assert rst with SW 0x55 @0x40 pending: after the edge LW @0x40 → 0 and FaultSticky=0.
